// File: rtl/pwm_pkg.sv
// Shared constants, phase encoding and duty clamp helper for the PWM core.
package pwm_pkg;

  // Width of period, delay and all counters
  localparam int WIDTH      = 26;
  // Full-scale duty value, i.e. 100 % expressed in basis points
  localparam int DUTY_SCALE = 10000;
  // Width of the duty input (10000 needs 14 bits)
  localparam int DUTY_W     = 14;
  // Width of period * duty before the divide; never truncated
  localparam int PROD_W     = 40;

  // Phase of the generator after reset or clear.
  // PH_DELAY: start-up delay is counting, output held low.
  // PH_ARM:   delay has expired, first period starts on the next edge.
  // PH_RUN:   periods are being generated.
  typedef enum logic [1:0] {
    PH_DELAY = 2'd0,
    PH_ARM   = 2'd1,
    PH_RUN   = 2'd2
  } phase_t;

  // Saturate a duty request at full scale so oversize values mean 100 %
  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty);
    return (duty > DUTY_W'(DUTY_SCALE)) ? DUTY_W'(DUTY_SCALE) : duty;
  endfunction

endpackage

// File: rtl/pwm_if.sv
// Configuration and status bundle between a PWM controller and the PWM core.
interface pwm_if;
  import pwm_pkg::*;

  logic [WIDTH-1:0]  period;
  logic [DUTY_W-1:0] duty;
  logic [WIDTH-1:0]  delay;
  logic              pwm_out;
  logic [WIDTH-1:0]  cnt;
  logic [WIDTH-1:0]  cnt0;
  logic              delay_done;

  // Controller side: supplies configuration, observes the waveform
  modport master (
    output period, duty, delay,
    input  pwm_out, cnt, cnt0, delay_done
  );

  // Core side: consumes configuration, produces the waveform
  modport slave (
    input  period, duty, delay,
    output pwm_out, cnt, cnt0, delay_done
  );

endinterface

// File: rtl/pwm_duty_calc.sv
// Converts (period, duty in basis points) into a high time in clock cycles.
// Purely combinational; the core samples the result only at period
// boundaries, so it is always settled when it is used.
module pwm_duty_calc
  import pwm_pkg::*;
(
  input  logic [WIDTH-1:0]  period,
  input  logic [DUTY_W-1:0] duty,
  output logic [WIDTH-1:0]  high_time
);

  logic [DUTY_W-1:0] duty_clamped;
  logic [PROD_W-1:0] product;

  // Clamp duty, form the full 40-bit product and floor-divide by full scale.
  // The quotient never exceeds period, so it always fits back into WIDTH bits.
  always_comb begin
    duty_clamped = clamp_duty(duty);
    product      = PROD_W'(period) * PROD_W'(duty_clamped);
    high_time    = WIDTH'(product / PROD_W'(DUTY_SCALE));
  end

endmodule

// File: rtl/pwm_core.sv
// Single-channel PWM generator with a programmable start-up delay.
// After reset or clear the output is held low for `delay` cycles, then
// periods of P cycles are generated with the output high for the first H.
// P and H are latched at every period start so mid-period changes of
// period/duty never produce a glitch.
module pwm_core
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  pwm_if.slave bus
);

  phase_t           state;
  phase_t           state_next;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] cnt0_q;
  logic [WIDTH-1:0] cnt0_next;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] h_q;
  logic [WIDTH-1:0] h_next;
  logic [WIDTH-1:0] h_calc;
  logic [WIDTH:0]   cnt0_inc;
  logic             delay_reached;
  logic             period_end;
  logic             dd_q;
  logic             dd_next;
  logic             pwm_q;
  logic             pwm_next;

  pwm_duty_calc u_duty_calc (
    .period    (bus.period),
    .duty      (bus.duty),
    .high_time (h_calc)
  );

  // Delay expires once the counter is one short of the (live) delay value;
  // the >= form also copes with delay being lowered below the count.
  always_comb begin
    cnt0_inc      = {1'b0, cnt0_q} + (WIDTH+1)'(1);
    delay_reached = (cnt0_inc >= {1'b0, bus.delay});
    period_end    = (p_q < WIDTH'(2)) || (cnt_q == p_q - WIDTH'(1));
  end

  // Phase sequencing: a zero delay starts the first period on the very first
  // edge, otherwise the period starts one edge after delay_done rises.
  always_comb begin
    state_next = state;
    case (state)
      PH_DELAY: begin
        if (bus.delay == '0) begin
          state_next = PH_RUN;
        end else if (delay_reached) begin
          state_next = PH_ARM;
        end
      end
      PH_ARM:  state_next = PH_RUN;
      PH_RUN:  state_next = PH_RUN;
      default: state_next = PH_DELAY;
    endcase
  end

  // Delay counter runs only in the delay phase and then freezes.
  always_comb begin
    cnt0_next = cnt0_q;
    dd_next   = (state_next != PH_DELAY);
    if (state == PH_DELAY) begin
      cnt0_next = cnt0_q + WIDTH'(1);
    end
  end

  // Period counter, boundary latching of P/H and next output level.
  always_comb begin
    cnt_next = '0;
    p_next   = p_q;
    h_next   = h_q;
    pwm_next = 1'b0;
    if (state_next == PH_RUN) begin
      if ((state != PH_RUN) || period_end) begin
        cnt_next = '0;
        p_next   = bus.period;
        h_next   = h_calc;
      end else begin
        cnt_next = cnt_q + WIDTH'(1);
      end
      pwm_next = (p_next >= WIDTH'(2)) && (cnt_next < h_next);
    end
  end

  // State and output registers; clear behaves like reset but synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= PH_DELAY;
      cnt_q  <= '0;
      cnt0_q <= '0;
      p_q    <= '0;
      h_q    <= '0;
      dd_q   <= 1'b0;
      pwm_q  <= 1'b0;
    end else if (clr) begin
      state  <= PH_DELAY;
      cnt_q  <= '0;
      cnt0_q <= '0;
      p_q    <= '0;
      h_q    <= '0;
      dd_q   <= 1'b0;
      pwm_q  <= 1'b0;
    end else begin
      state  <= state_next;
      cnt_q  <= cnt_next;
      cnt0_q <= cnt0_next;
      p_q    <= p_next;
      h_q    <= h_next;
      dd_q   <= dd_next;
      pwm_q  <= pwm_next;
    end
  end

  assign bus.pwm_out    = pwm_q;
  assign bus.cnt        = cnt_q;
  assign bus.cnt0       = cnt0_q;
  assign bus.delay_done = dd_q;

endmodule

// File: tb/tb_pwm_core.sv
// Directed testbench for pwm_core: delay phase, duty/period latching,
// degenerate periods, asynchronous reset and synchronous clear.
module tb_pwm_core;
  import pwm_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clr   = 1'b0;

  int check_count = 0;
  int pass_count  = 0;

  pwm_if bus_if ();

  pwm_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus_if)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Guard against a stuck run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", check_count);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic applyStimulus(input int p, input int d, input int dl);
    bus_if.period = WIDTH'(p);
    bus_if.duty   = DUTY_W'(d);
    bus_if.delay  = WIDTH'(dl);
  endtask

  // Advance n edges, leaving time 1 unit after the last rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse reset across one edge; releases just after an edge so the
  // next rising edge is edge 1 after release
  task automatic applyReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clr   = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  // Edges until pwm_out reaches level (returns limit on timeout)
  task automatic edgesUntil(input logic level, input int limit, output int n);
    n = 0;
    while (bus_if.pwm_out !== level && n < limit) begin
      step(1);
      n++;
    end
  endtask

  task automatic edgesUntilDone(input int limit, output int n);
    n = 0;
    while (bus_if.delay_done !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
  endtask

  // Count cycles over n edges where the output is high or cnt is nonzero
  task automatic countActive(input int n, output int highs, output int nonzero);
    highs   = 0;
    nonzero = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (bus_if.pwm_out === 1'b1) highs++;
      if (bus_if.cnt !== '0) nonzero++;
    end
  endtask

  initial begin
    int n;
    int highs;
    int nonzero;

    // 50 % duty, no delay
    $display("[TB] test: 1598 cycles, 50 %%, delay 0");
    applyStimulus(1598, 5000, 0);
    #1 rst_n = 1'b0;
    #20;
    checkOutput("reset_pwm", 32'(bus_if.pwm_out), 32'd0);
    checkOutput("reset_cnt", 32'(bus_if.cnt), 32'd0);
    checkOutput("reset_cnt0", 32'(bus_if.cnt0), 32'd0);
    checkOutput("reset_done", 32'(bus_if.delay_done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    edgesUntil(1'b1, 20, n);
    checkOutput("t1_first_rise", 32'(n), 32'd1);
    checkOutput("t1_done", 32'(bus_if.delay_done), 32'd1);
    checkOutput("t1_cnt_at_rise", 32'(bus_if.cnt), 32'd0);
    edgesUntil(1'b0, 2000, n);
    checkOutput("t1_high", 32'(n), 32'd799);
    edgesUntil(1'b1, 2000, n);
    checkOutput("t1_low", 32'(n), 32'd799);
    edgesUntil(1'b0, 2000, n);
    checkOutput("t1_high2", 32'(n), 32'd799);

    // 25 % duty with 10-cycle start-up delay
    $display("[TB] test: 1000 cycles, 25 %%, delay 10");
    applyStimulus(1000, 2500, 10);
    applyReset();
    edgesUntilDone(50, n);
    checkOutput("t2_done_edges", 32'(n), 32'd10);
    checkOutput("t2_pwm_at_done", 32'(bus_if.pwm_out), 32'd0);
    checkOutput("t2_cnt0_at_done", 32'(bus_if.cnt0), 32'd10);
    edgesUntil(1'b1, 50, n);
    checkOutput("t2_rise_after_done", 32'(n), 32'd1);
    checkOutput("t2_cnt0_hold", 32'(bus_if.cnt0), 32'd10);
    edgesUntil(1'b0, 2000, n);
    checkOutput("t2_high", 32'(n), 32'd250);
    edgesUntil(1'b1, 2000, n);
    checkOutput("t2_low", 32'(n), 32'd750);

    // Duty 0 then oversize duty, period 100
    $display("[TB] test: duty 0 then 12000");
    applyStimulus(100, 0, 0);
    applyReset();
    countActive(250, highs, nonzero);
    checkOutput("t3_zero_duty_highs", 32'(highs), 32'd0);
    checkOutput("t3_cnt_mid", 32'(bus_if.cnt), 32'd49);
    bus_if.duty = DUTY_W'(12000);
    edgesUntil(1'b1, 200, n);
    checkOutput("t3_rise_at_boundary", 32'(n), 32'd51);
    checkOutput("t3_cnt_at_rise", 32'(bus_if.cnt), 32'd0);
    countActive(200, highs, nonzero);
    checkOutput("t3_full_duty_highs", 32'(highs), 32'd200);

    // Duty change in the middle of a period
    $display("[TB] test: duty 5000 -> 1000 mid-period");
    applyStimulus(200, 5000, 0);
    applyReset();
    step(51);
    checkOutput("t4_cnt_mid", 32'(bus_if.cnt), 32'd50);
    bus_if.duty = DUTY_W'(1000);
    edgesUntil(1'b0, 500, n);
    checkOutput("t4_rest_of_high", 32'(n), 32'd50);
    edgesUntil(1'b1, 500, n);
    checkOutput("t4_old_low", 32'(n), 32'd100);
    edgesUntil(1'b0, 500, n);
    checkOutput("t4_new_high", 32'(n), 32'd20);
    edgesUntil(1'b1, 500, n);
    checkOutput("t4_new_low", 32'(n), 32'd180);

    // Asynchronous reset in the middle of a period
    $display("[TB] test: reset at cnt 50, delay 5");
    applyStimulus(100, 5000, 5);
    applyReset();
    edgesUntil(1'b1, 50, n);
    checkOutput("t5_first_rise", 32'(n), 32'd6);
    step(50);
    checkOutput("t5_cnt_before_rst", 32'(bus_if.cnt), 32'd50);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_async_pwm", 32'(bus_if.pwm_out), 32'd0);
    checkOutput("t5_async_cnt", 32'(bus_if.cnt), 32'd0);
    checkOutput("t5_async_cnt0", 32'(bus_if.cnt0), 32'd0);
    checkOutput("t5_async_done", 32'(bus_if.delay_done), 32'd0);
    #2;
    rst_n = 1'b1;
    edgesUntil(1'b1, 50, n);
    checkOutput("t5_rise_after_rst", 32'(n), 32'd6);

    // Degenerate periods 1 and 0
    $display("[TB] test: period 1 and 0");
    applyStimulus(1, 5000, 0);
    applyReset();
    countActive(50, highs, nonzero);
    checkOutput("t6_p1_highs", 32'(highs), 32'd0);
    checkOutput("t6_p1_cnt", 32'(nonzero), 32'd0);
    checkOutput("t6_p1_done", 32'(bus_if.delay_done), 32'd1);
    bus_if.period = WIDTH'(0);
    bus_if.duty   = DUTY_W'(10000);
    countActive(50, highs, nonzero);
    checkOutput("t6_p0_highs", 32'(highs), 32'd0);
    checkOutput("t6_p0_cnt", 32'(nonzero), 32'd0);

    // Synchronous clear mid-run
    $display("[TB] test: clear pulse mid-run, delay 3");
    applyStimulus(100, 5000, 3);
    applyReset();
    edgesUntil(1'b1, 50, n);
    checkOutput("t7_first_rise", 32'(n), 32'd4);
    step(10);
    clr = 1'b1;
    #2;
    checkOutput("t7_clr_is_sync", 32'(bus_if.cnt), 32'd10);
    step(1);
    clr = 1'b0;
    checkOutput("t7_clr_pwm", 32'(bus_if.pwm_out), 32'd0);
    checkOutput("t7_clr_cnt0", 32'(bus_if.cnt0), 32'd0);
    checkOutput("t7_clr_done", 32'(bus_if.delay_done), 32'd0);
    edgesUntil(1'b1, 50, n);
    checkOutput("t7_rise_after_clr", 32'(n), 32'd4);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/pwm_core.md
# pwm_core

Programmable single-channel PWM generator with a start-up delay, driven from one (PLL-derived) clock. Period, duty cycle and initial delay are runtime inputs; duty is expressed in basis points (0..10000 = 0..100 %). The block sits downstream of the clock-generation PLLs, which are vendor IP and outside this spec. It produces the modulation waveform for the VPPM transmit/receive path.

## Interface
- `WIDTH`, 26: width of period, delay and counters.
- `DUTY_SCALE`, 10000: full-scale duty value (100 %).
- `clk`  in  1  PWM timebase clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous, active-high clear; same effect as reset, taking effect at the next edge.
- `period`  in  WIDTH  PWM period in clk cycles.
- `duty`  in  14  high time in basis points of `period`.
- `delay`  in  WIDTH  clk cycles the output is held low before the first period.
- `pwm_out`  out  1  PWM waveform, registered.
- `cnt`  out  WIDTH  position within the current period.
- `cnt0`  out  WIDTH  start-up delay counter.
- `delay_done`  out  1  high once the start-up delay has expired.

## Operation
- Reset/clear state: `pwm_out`=0, `cnt`=0, `cnt0`=0, `delay_done`=0.
- Delay phase, while `delay_done`=0:
  - `cnt0` increments each cycle.
  - When `cnt0` = `delay`−1, `delay_done` is set on the next edge. With `delay`=0, it is set on the first edge after reset.
  - `pwm_out` stays 0 throughout.
  - `delay` is sampled continuously during this phase and ignored afterwards.
  - `cnt0` holds its final value once `delay_done`=1.
- Run phase:
  - `cnt` counts 0..P−1 and wraps to 0. P is the latched period.
  - At every `cnt`=0 cycle, the block latches P=`period` and H=floor(P·D/10000), where D=min(`duty`,10000).
  - `pwm_out`=1 in cycles with `cnt` < H, otherwise 0.
  - Changes to `period` or `duty` take effect only at the next period boundary, so no glitches occur.
- Degenerate values:
  - P<2: `pwm_out` held 0, `cnt` held 0, reloaded every cycle.
  - D=0: output constant low.
  - D≥10000: output constant high (for P≥2).
- Arithmetic: the P·D product is 40 bits and is not truncated before the divide. The divide by DUTY_SCALE must be exact floor, using any synthesizable method.

## Timing
- All outputs are registered and change only on rising `clk`, or asynchronously on `rst_n` falling.
- `pwm_out`, `cnt` and `delay_done` are mutually consistent in the same cycle; there is no extra output stage.
- First run-phase cycle (`cnt`=0) is the cycle after `delay_done` rises. `pwm_out` is high in that cycle if H>0.
- First `pwm_out` rise occurs exactly `delay`+1 edges after `rst_n` deasserts.
- `rst_n` asserted mid-period: outputs clear immediately. After release, the sequence restarts with a full delay phase.
- `clr` has the same effect synchronously. `clr` together with `rst_n` low: reset wins.
- Output high time = H cycles; low time = P−H cycles.

## Structure
- Shared package `pwm_pkg`: `WIDTH`, `DUTY_SCALE`, duty width (14), product width (40).
- One sub-module `pwm_duty_calc`: (period, duty) → H, with clamp and floor divide. It is combinational or pipelined; if pipelined, the result must be ready before the next `cnt`=0.
- The PLL wrappers are not part of this block.

## Test plan
- `period`=1598, `duty`=5000, `delay`=0 → `pwm_out` 799 cycles high / 799 low, repeating; first rise 1 edge after reset release.
- `period`=1000, `duty`=2500, `delay`=10 → `pwm_out` low for 11 edges, then 250 high / 750 low; `delay_done` rises after 10 edges.
- `duty`=0, then `duty`=12000 (`period`=100) → constant 0, then constant 1 starting exactly at the next `cnt`=0.
- `duty` changed 5000→1000 mid-period (`period`=200) → current period stays 100/100; next period is 20/180.
- `rst_n` pulsed low at `cnt`=50 (`delay`=5) → all outputs 0 immediately; delay phase repeats; output resumes 6 edges after release.
- `period`=1 or 0 → `pwm_out` stays 0 and `cnt` stays 0; `clr` pulse mid-run → same restart as reset, one edge later.
